// File: rtl/adc_fifo_drain_scheduler.sv
// Round-robin drain of per-channel ADC sample FIFOs onto one valid/ready stream:
// one word per channel per frame, with a fill word for a channel that stays empty.
module adc_fifo_drain_scheduler #(
  parameter int                NUM_CH         = 4,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] FILL_WORD      = '0,
  parameter int                FRAME_W        = 16,
  localparam int               CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int               TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        fifo_rdempty,
  input  logic [NUM_CH*DATA_W-1:0] fifo_q,
  output logic [NUM_CH-1:0]        fifo_rdreq,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_channel,
  output logic                     out_sof,
  output logic                     out_missing,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FRAME_W-1:0]       frame_count,
  output logic [15:0]              missed_count,
  output logic                     busy
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [TO_W-1:0]     timer_q, timer_d;
  logic [NUM_CH-1:0]   rdreq_q, rdreq_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CH_W-1:0]     out_channel_q, out_channel_d;
  logic                out_sof_q, out_sof_d;
  logic                out_missing_q, out_missing_d;
  logic                out_valid_q, out_valid_d;
  logic [FRAME_W-1:0]  frame_count_q, frame_count_d;
  logic [15:0]         missed_count_q, missed_count_d;

  logic                ch_empty;
  logic [DATA_W-1:0]   ch_data;

  // Constant part-selects keep the channel mux clean for any NUM_CH, power of two or not.
  always_comb begin
    ch_empty = 1'b1;
    ch_data  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_q == CH_W'(n)) begin
        ch_empty = fifo_rdempty[n];
        ch_data  = fifo_q[n*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: every signal gets its hold value first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    timer_d        = timer_q;
    rdreq_d        = '0;
    out_data_d     = out_data_q;
    out_channel_d  = out_channel_q;
    out_sof_d      = out_sof_q;
    out_missing_d  = out_missing_q;
    out_valid_d    = out_valid_q;
    frame_count_d  = frame_count_q;
    missed_count_d = missed_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CHECK;
          ch_d    = '0;
          timer_d = '0;
        end
      end

      ST_CHECK: begin
        // A word arriving on the last timeout cycle is still read, never filled.
        if (!ch_empty) begin
          rdreq_d[ch_q] = 1'b1;
          state_d       = ST_REQ;
        end else if (timer_q == TO_LAST) begin
          out_data_d    = FILL_WORD;
          out_missing_d = 1'b1;
          out_channel_d = ch_q;
          out_sof_d     = (ch_q == '0);
          out_valid_d   = 1'b1;
          if (missed_count_q != 16'hFFFF) begin
            missed_count_d = missed_count_q + 16'd1;
          end
          state_d = ST_SEND;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        out_data_d    = ch_data;
        out_missing_d = 1'b0;
        out_channel_d = ch_q;
        out_sof_d     = (ch_q == '0);
        out_valid_d   = 1'b1;
        state_d       = ST_SEND;
      end

      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          timer_d     = '0;
          if (ch_q != LAST_CH) begin
            ch_d    = ch_q + CH_W'(1);
            state_d = ST_CHECK;
          end else begin
            // Frame boundary: the only point after IDLE where enable is looked at.
            frame_count_d = frame_count_q + FRAME_W'(1);
            ch_d          = '0;
            state_d       = enable ? ST_CHECK : ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples the values from
  // before this edge, independent of statement order.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ch_q           <= '0;
      timer_q        <= '0;
      rdreq_q        <= '0;
      out_data_q     <= '0;
      out_channel_q  <= '0;
      out_sof_q      <= 1'b0;
      out_missing_q  <= 1'b0;
      out_valid_q    <= 1'b0;
      frame_count_q  <= '0;
      missed_count_q <= '0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      timer_q        <= timer_d;
      rdreq_q        <= rdreq_d;
      out_data_q     <= out_data_d;
      out_channel_q  <= out_channel_d;
      out_sof_q      <= out_sof_d;
      out_missing_q  <= out_missing_d;
      out_valid_q    <= out_valid_d;
      frame_count_q  <= frame_count_d;
      missed_count_q <= missed_count_d;
    end
  end

  assign fifo_rdreq   = rdreq_q;
  assign out_data     = out_data_q;
  assign out_channel  = out_channel_q;
  assign out_sof      = out_sof_q;
  assign out_missing  = out_missing_q;
  assign out_valid    = out_valid_q;
  assign frame_count  = frame_count_q;
  assign missed_count = missed_count_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_fifo_drain_scheduler.sv
// Self-checking bench: FIFO model in front of the scheduler, beat scoreboard
// behind it, plus directed scenarios with literal expectations.
module tb_adc_fifo_drain_scheduler;

  localparam int               NUM_CH  = 4;
  localparam int               DATA_W  = 32;
  localparam int               TO_CYC  = 16;
  localparam int               FRAME_W = 2;
  localparam logic [31:0]      FILL    = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  ch;
    logic        sof;
    logic        missing;
  } beat_t;

  logic                     clk;
  logic                     reset;
  logic                     enable;
  logic [NUM_CH-1:0]        fifo_rdempty;
  logic [NUM_CH*DATA_W-1:0] fifo_q;
  logic [NUM_CH-1:0]        fifo_rdreq;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               out_channel;
  logic                     out_sof;
  logic                     out_missing;
  logic                     out_valid;
  logic                     out_ready;
  logic [FRAME_W-1:0]       frame_count;
  logic [15:0]              missed_count;
  logic                     busy;

  adc_fifo_drain_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC),
    .FILL_WORD(FILL), .FRAME_W(FRAME_W)
  ) dut (
    .system_clock(clk), .reset(reset), .enable(enable),
    .fifo_rdempty(fifo_rdempty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .out_data(out_data), .out_channel(out_channel), .out_sof(out_sof),
    .out_missing(out_missing), .out_valid(out_valid), .out_ready(out_ready),
    .frame_count(frame_count), .missed_count(missed_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Non-showahead FIFO model: q updates one edge after rdreq.
  logic [31:0] mem [NUM_CH][64];
  int          wr_ptr [NUM_CH];
  int          rd_ptr [NUM_CH];
  logic [31:0] fifo_q_r [NUM_CH];
  int          rdreq_cnt [NUM_CH];
  int          cyc = 0;

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      fifo_rdempty[n]        = (rd_ptr[n] == wr_ptr[n]);
      fifo_q[n*DATA_W +: 32] = fifo_q_r[n];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int n = 0; n < NUM_CH; n++) begin
      if (fifo_rdreq[n]) rdreq_cnt[n] <= rdreq_cnt[n] + 1;
      if (fifo_rdreq[n] && rd_ptr[n] != wr_ptr[n]) begin
        fifo_q_r[n] <= mem[n][rd_ptr[n] % 64];
        rd_ptr[n]   <= rd_ptr[n] + 1;
      end
    end
  end

  // Scoreboard: expected beats in stream order, frame and fill tallies.
  beat_t exp_q[$];
  int    hs_cyc[$];
  int    exp_frames = 0;
  int    exp_missed = 0;
  logic  prev_valid = 1'b0;
  logic  prev_ready = 1'b0;
  logic  [NUM_CH-1:0] prev_rdreq = '0;
  beat_t prev_beat;

  task automatic push_word(input int ch, input logic [31:0] d);
    mem[ch][wr_ptr[ch] % 64] = d;
    wr_ptr[ch]++;
  endtask

  task automatic expect_beat(input logic [31:0] d, input int ch, input logic missing);
    beat_t b;
    b.data    = d;
    b.ch      = 2'(ch);
    b.sof     = (ch == 0);
    b.missing = missing;
    exp_q.push_back(b);
  endtask

  task automatic load_frame(input logic [31:0] base, input int skip_ch);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (ch == skip_ch) begin
        expect_beat(FILL, ch, 1'b1);
      end else begin
        push_word(ch, base + 32'(ch));
        expect_beat(base + 32'(ch), ch, 1'b0);
      end
    end
  endtask

  task automatic flush_fifos();
    for (int n = 0; n < NUM_CH; n++) wr_ptr[n] = rd_ptr[n];
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_frames = 0;
      exp_missed = 0;
      prev_valid = 1'b0;
      prev_rdreq = '0;
    end else begin
      check("rdreq_onehot", 64'($countones(fifo_rdreq) <= 1), 1);
      if (prev_rdreq != '0) check("rdreq_pulse", fifo_rdreq, 0);
      if (out_valid) check("rdreq_in_send", fifo_rdreq, 0);
      for (int n = 0; n < NUM_CH; n++)
        if (fifo_rdreq[n]) check("rdreq_on_empty", fifo_rdempty[n], 0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", out_valid, 1);
        check("hold_beat", {out_data, out_channel, out_sof, out_missing}, prev_beat);
      end
      check("frame_count", frame_count, 64'(exp_frames % (1 << FRAME_W)));
      if (!out_valid) check("missed_count", missed_count, 64'(exp_missed));
      if (out_valid || fifo_rdreq != '0) check("busy_active", busy, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_data, out_channel}, 0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", out_data, e.data);
          check("beat_channel", out_channel, e.ch);
          check("beat_sof", out_sof, e.sof);
          check("beat_missing", out_missing, e.missing);
          if (e.ch == 2'(NUM_CH - 1)) exp_frames++;
          if (e.missing) exp_missed++;
        end
        hs_cyc.push_back(cyc);
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_rdreq = fifo_rdreq;
      prev_beat  = {out_data, out_channel, out_sof, out_missing};
    end
  end

  task automatic wait_beat(input int ch, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(out_valid && out_channel == 2'(ch)) && n < budget);
    check("wait_beat_reached", 64'(out_valid && out_channel == 2'(ch)), 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
    check("drain_done", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdreq"}, fifo_rdreq, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_channel"}, out_channel, 0);
    check({tag, "_sof"}, out_sof, 0);
    check({tag, "_missing"}, out_missing, 0);
    check({tag, "_frames"}, frame_count, 0);
    check({tag, "_missed"}, missed_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int snap [NUM_CH];
    int fc_exp [4] = '{1, 2, 3, 0};

    reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // Full frame, ready always high: 4-cycle beat spacing, 4-cycle first latency.
    load_frame(32'hA0, -1);
    hs_cyc.delete();
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
    check("first_beat_latency", n, 4);
    enable = 1'b0;
    drain(100);
    check("t1_frame_count", frame_count, 1);
    check("t1_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("t1_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 4);

    // Backpressure for 10 cycles on the ch1 beat.
    load_frame(32'hB0, -1);
    out_ready = 1'b0;
    enable = 1'b1;
    wait_beat(0, 30);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_beat(1, 30);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t2_stall_valid", out_valid, 1);
      check("t2_stall_channel", out_channel, 1);
      check("t2_stall_data", out_data, 32'hB1);
      check("t2_stall_rdreq", fifo_rdreq, 0);
    end
    out_ready = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    check("t2_accept_no_rdreq", fifo_rdreq, 0);
    @(posedge clk); #1;
    check("t2_ch2_rdreq", fifo_rdreq, 4'b0100);
    drain(100);
    check("t2_frame_count", frame_count, 2);

    // ch2 stays empty: 16 CHECK cycles then a fill beat.
    snap = rdreq_cnt;
    hs_cyc.delete();
    load_frame(32'hC0, 2);
    enable = 1'b1;
    wait_beat(0, 30);
    enable = 1'b0;
    drain(150);
    check("t3_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) begin
      check("t3_gap_ch1", 64'(hs_cyc[1] - hs_cyc[0]), 4);
      check("t3_gap_fill", 64'(hs_cyc[2] - hs_cyc[1]), TO_CYC + 1);
      check("t3_gap_ch3", 64'(hs_cyc[3] - hs_cyc[2]), 4);
    end
    check("t3_missed", missed_count, 1);
    check("t3_ch2_reads", 64'(rdreq_cnt[2] - snap[2]), 0);
    check("t3_ch3_reads", 64'(rdreq_cnt[3] - snap[3]), 1);
    check("t3_frame_count", frame_count, 3);

    // enable drops during the ch1 beat: frame completes, no new ch0 read.
    load_frame(32'hD0, -1);
    push_word(0, 32'hDF);
    snap = rdreq_cnt;
    enable = 1'b1;
    wait_beat(1, 40);
    enable = 1'b0;
    drain(100);
    check("t4_frame_wrap", frame_count, 0);
    check("t4_busy", busy, 0);
    check("t4_ch0_reads", 64'(rdreq_cnt[0] - snap[0]), 1);
    check("t4_ch0_left", 64'(wr_ptr[0] - rd_ptr[0]), 1);
    flush_fifos();

    // Reset while ch1 is in its read-latency cycle.
    load_frame(32'hE0, -1);
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fifo_rdreq[1] && n < 30);
    check("t5_ch1_rdreq", fifo_rdreq[1], 1);
    enable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_reset_values("t5_rst");
    flush_fifos();
    @(posedge clk); #1;
    reset = 1'b0;
    load_frame(32'hF0, -1);
    enable = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!out_valid && n < 20);
    check("t5_first_channel", out_channel, 0);
    check("t5_first_sof", out_sof, 1);
    check("t5_first_data", out_data, 32'hF0);
    enable = 1'b0;
    drain(100);
    check("t5_frame_count", frame_count, 1);

    // Four back-to-back frames with a 2-bit frame counter.
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int f = 0; f < 4; f++) load_frame(32'h100 + 32'(f * 16), -1);
    enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_beat(3, 60);
      if (f == 3) enable = 1'b0;
      @(posedge clk); #1;
      check("t6_frame_count", frame_count, 64'(fc_exp[f]));
    end
    drain(200);
    check("t6_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
